// File: rtl/psum_accum_buf_pkg.sv
// Shared parameters, FSM state encoding and the psum sign-extension helper
// used by the partial-sum accumulator buffer.
package psum_accum_buf_pkg;

   localparam int PE_COL   = 8;
   localparam int BIT_PSUM = 24;
   localparam int BIT_ADDR = 4;
   localparam int BIT_ACC  = 32;
   localparam int DEPTH    = 2 ** BIT_ADDR;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic signed [BIT_ACC-1:0] sextPsum(input logic [BIT_PSUM-1:0] psum);
      return {{(BIT_ACC-BIT_PSUM){psum[BIT_PSUM-1]}}, psum};
   endfunction

endpackage

// File: rtl/psum_accum_buf_if.sv
// Array-side psum inputs and the drain valid/ready port of the accumulator
// buffer; slave is the buffer, master is whoever drives the array side.
interface psum_accum_buf_if;
   import psum_accum_buf_pkg::*;

   logic [PE_COL*BIT_PSUM-1:0] i_Psum_In;
   logic [PE_COL*BIT_ADDR-1:0] i_Addr_P_In;
   logic [PE_COL-1:0]          i_Valid_P_In;
   logic                       i_Drain_Start;
   logic [PE_COL*BIT_ACC-1:0]  o_Out_Data;
   logic [BIT_ADDR-1:0]        o_Out_Addr;
   logic                       o_Out_Valid;
   logic                       i_Out_Ready;
   logic                       o_Busy;
   logic                       o_Done;
   logic                       o_Drop;

   modport slave (
      input  i_Psum_In, i_Addr_P_In, i_Valid_P_In, i_Drain_Start, i_Out_Ready,
      output o_Out_Data, o_Out_Addr, o_Out_Valid, o_Busy, o_Done, o_Drop
   );

   modport master (
      output i_Psum_In, i_Addr_P_In, i_Valid_P_In, i_Drain_Start, i_Out_Ready,
      input  o_Out_Data, o_Out_Addr, o_Out_Valid, o_Busy, o_Done, o_Drop
   );

endinterface

// File: rtl/psum_accum_buf_col_bank.sv
// One column's DEPTH x BIT_ACC accumulator bank: single-cycle read-modify-write
// accumulate port plus a combinational read / clear port. Optional PSUM_SAT_EN.
module psum_col_bank
   import psum_accum_buf_pkg::*;
(
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       i_Acc_En,
   input  logic [BIT_ADDR-1:0]        i_Acc_Addr,
   input  logic [BIT_PSUM-1:0]        i_Psum,
   input  logic [BIT_ADDR-1:0]        i_Rd_Addr,
   input  logic                       i_Clr_En,
   output logic signed [BIT_ACC-1:0]  o_Rd_Data
);

   logic signed [BIT_ACC-1:0] r_Mem [DEPTH];
   logic signed [BIT_ACC-1:0] w_Old;
   logic signed [BIT_ACC-1:0] w_Ext;
   logic signed [BIT_ACC-1:0] w_Sum;
   logic signed [BIT_ACC-1:0] w_New;

   assign w_Old     = r_Mem[i_Acc_Addr];
   assign w_Ext     = sextPsum(i_Psum);
   assign w_Sum     = w_Old + w_Ext;
   assign o_Rd_Data = r_Mem[i_Rd_Addr];

`ifdef PSUM_SAT_EN
   // Overflow only when both operands share a sign the result does not.
   logic w_Ovf;
   assign w_Ovf = (w_Old[BIT_ACC-1] == w_Ext[BIT_ACC-1]) && (w_Sum[BIT_ACC-1] != w_Old[BIT_ACC-1]);

   always_comb begin
      w_New = w_Sum;
      if (w_Ovf) begin
         w_New = w_Old[BIT_ACC-1] ? {1'b1, {(BIT_ACC-1){1'b0}}} : {1'b0, {(BIT_ACC-1){1'b1}}};
      end
   end
`else
   assign w_New = w_Sum;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_Mem[i] <= '0;
         end
      end else begin
         if (i_Clr_En) begin
            r_Mem[i_Rd_Addr] <= '0;
         end
         if (i_Acc_En) begin
            r_Mem[i_Acc_Addr] <= w_New;
         end
      end
   end

endmodule

// File: rtl/psum_accum_buf.sv
// Partial-sum accumulator under the systolic array: per-column banks, drain FSM,
// drain pointer and sticky drop flag. Build option: PSUM_SAT_EN (saturating adds).
module psum_accum_buf
   import psum_accum_buf_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   psum_accum_buf_if.slave   bus
);

   state_t                    r_State;
   state_t                    w_NextState;
   logic [BIT_ADDR-1:0]       r_Ptr;
   logic                      r_Drop;
   logic                      w_Accept;
   logic                      w_LastBeat;
   logic signed [BIT_ACC-1:0] w_RdData [PE_COL];

   assign w_Accept   = (r_State == ST_DRAIN) && bus.i_Out_Ready;
   assign w_LastBeat = w_Accept && (r_Ptr == BIT_ADDR'(DEPTH-1));

   always_comb begin
      w_NextState = r_State;
      case (r_State)
         ST_IDLE:  if (bus.i_Drain_Start) w_NextState = ST_DRAIN;
         ST_DRAIN: if (w_LastBeat) w_NextState = ST_DONE;
         ST_DONE:  w_NextState = ST_IDLE;
         default:  w_NextState = ST_IDLE;
      endcase
   end

   // The pointer wraps to 0 on the last accepted beat, so DONE and IDLE present Addr 0.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_State <= ST_IDLE;
         r_Ptr   <= '0;
         r_Drop  <= 1'b0;
      end else begin
         r_State <= w_NextState;
         if (w_Accept) begin
            r_Ptr <= r_Ptr + BIT_ADDR'(1);
         end
         if ((r_State == ST_DRAIN) && (|bus.i_Valid_P_In)) begin
            r_Drop <= 1'b1;
         end
      end
   end

   genvar c;
   generate
      for (c = 0; c < PE_COL; c++) begin : g_col
         psum_col_bank u_bank (
            .CLK        (CLK),
            .RST        (RST),
            .i_Acc_En   (bus.i_Valid_P_In[c] && (r_State != ST_DRAIN)),
            .i_Acc_Addr (bus.i_Addr_P_In[BIT_ADDR*c +: BIT_ADDR]),
            .i_Psum     (bus.i_Psum_In[BIT_PSUM*c +: BIT_PSUM]),
            .i_Rd_Addr  (r_Ptr),
            .i_Clr_En   (w_Accept),
            .o_Rd_Data  (w_RdData[c])
         );
      end
   endgenerate

   always_comb begin
      bus.o_Out_Data = '0;
      for (int k = 0; k < PE_COL; k++) begin
         bus.o_Out_Data[BIT_ACC*k +: BIT_ACC] = w_RdData[k];
      end
   end

   assign bus.o_Out_Addr  = r_Ptr;
   assign bus.o_Out_Valid = (r_State == ST_DRAIN);
   assign bus.o_Busy      = (r_State == ST_DRAIN);
   assign bus.o_Done      = (r_State == ST_DONE);
   assign bus.o_Drop      = r_Drop;

endmodule

// File: tb/tb_psum_accum_buf.sv
// Scoreboard bench for psum_accum_buf: directed psum vectors, hand-computed drain
// beats queued by the stimulus and popped by an independent output monitor.
module tb_psum_accum_buf;
   import psum_accum_buf_pkg::*;

   localparam int DW = PE_COL*BIT_ACC;

   typedef struct packed {
      logic [BIT_ADDR-1:0] addr;
      logic [DW-1:0]       data;
   } beat_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   psum_accum_buf_if bus();

   psum_accum_buf dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   beat_t                     scbQ[$];
   logic signed [BIT_ACC-1:0] expRow [DEPTH][PE_COL];
   int                        checks = 0;
   int                        passes = 0;

   task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   task automatic clearExp();
      for (int a = 0; a < DEPTH; a++)
         for (int c = 0; c < PE_COL; c++)
            expRow[a][c] = '0;
   endtask

   task automatic setCol(input int col, input int addr, input int val);
      bus.i_Valid_P_In[col] = 1'b1;
      bus.i_Addr_P_In[BIT_ADDR*col +: BIT_ADDR] = BIT_ADDR'(addr);
      bus.i_Psum_In[BIT_PSUM*col +: BIT_PSUM]   = BIT_PSUM'(val);
   endtask

   // One clock with whatever is currently staged, then drop the one-shot inputs.
   task automatic applyStimulus();
      @(posedge CLK);
      #1;
      bus.i_Valid_P_In  = '0;
      bus.i_Drain_Start = 1'b0;
   endtask

   // readyMode 0: always ready; 1: ready pattern 1,0,0 repeating. dropCyc >= 0 injects a col2 psum.
   task automatic runDrain(input int readyMode, input int dropCyc);
      beat_t b;
      int    doneCycles = 0;
      bit    finished = 0;
      for (int a = 0; a < DEPTH; a++) begin
         b.addr = BIT_ADDR'(a);
         for (int c = 0; c < PE_COL; c++) b.data[BIT_ACC*c +: BIT_ACC] = expRow[a][c];
         scbQ.push_back(b);
      end
      bus.i_Drain_Start = 1'b1;
      applyStimulus();
      for (int k = 0; k < 300 && !finished; k++) begin
         bus.i_Out_Ready  = (readyMode == 0) ? 1'b1 : (k % 3 == 0);
         bus.i_Valid_P_In = '0;
         if (k == dropCyc) setCol(2, 5, 77);
         @(negedge CLK);
         if (bus.o_Done) doneCycles++;
         else if (doneCycles > 0) finished = 1;
         @(posedge CLK);
         #1;
      end
      bus.i_Out_Ready  = 1'b0;
      bus.i_Valid_P_In = '0;
      checkOutput("drain finished in budget", DW'(finished), DW'(1));
      checkOutput("done pulse width", DW'(doneCycles), DW'(1));
      checkOutput("all beats consumed", DW'(scbQ.size()), DW'(0));
      scbQ.delete();
   endtask

   // Monitor: compares every accepted beat and checks that stalled beats hold steady.
   logic                prevStall = 1'b0;
   logic [BIT_ADDR-1:0] prevAddr;
   logic [DW-1:0]       prevData;
   always @(negedge CLK) begin
      beat_t e;
      if (!RST && bus.o_Out_Valid) begin
         if (prevStall) begin
            checkOutput("stall addr hold", DW'(bus.o_Out_Addr), DW'(prevAddr));
            checkOutput("stall data hold", bus.o_Out_Data, prevData);
         end
         if (bus.i_Out_Ready) begin
            if (scbQ.size() == 0) begin
               checkOutput("unexpected beat", DW'(1), DW'(0));
            end else begin
               e = scbQ.pop_front();
               checkOutput("beat addr", DW'(bus.o_Out_Addr), DW'(e.addr));
               checkOutput("beat data", bus.o_Out_Data, e.data);
            end
         end
      end
      prevStall = !RST && bus.o_Out_Valid && !bus.i_Out_Ready;
      prevAddr  = bus.o_Out_Addr;
      prevData  = bus.o_Out_Data;
   end

   initial begin
      bus.i_Psum_In     = '0;
      bus.i_Addr_P_In   = '0;
      bus.i_Valid_P_In  = '0;
      bus.i_Drain_Start = 1'b0;
      bus.i_Out_Ready   = 1'b0;
      clearExp();
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      checkOutput("reset valid", DW'(bus.o_Out_Valid), DW'(0));
      checkOutput("reset busy", DW'(bus.o_Busy), DW'(0));
      checkOutput("reset done", DW'(bus.o_Done), DW'(0));
      checkOutput("reset drop", DW'(bus.o_Drop), DW'(0));
      checkOutput("reset addr", DW'(bus.o_Out_Addr), DW'(0));
      @(posedge CLK);
      #1;

      $display("[TB] test 1: drain after reset");
      runDrain(0, -1);

      $display("[TB] test 2: accumulate col0/col1 at addr 3");
      setCol(0, 3, 5);
      setCol(1, 3, 100);
      applyStimulus();
      setCol(0, 3, 7);
      applyStimulus();
      setCol(0, 3, -2);
      applyStimulus();
      expRow[3][0] = 10;
      expRow[3][1] = 100;
      runDrain(0, -1);

      $display("[TB] test 3: stalled drain then second drain");
      clearExp();
      setCol(4, 9, -300);
      setCol(7, 15, 1234);
      applyStimulus();
      expRow[9][4]  = -300;
      expRow[15][7] = 1234;
      runDrain(1, -1);
      clearExp();
      runDrain(0, -1);

      $display("[TB] test 4: psum during drain is dropped");
      runDrain(0, 2);
      @(negedge CLK);
      checkOutput("drop sticky after done", DW'(bus.o_Drop), DW'(1));
      @(posedge CLK);
      #1;
      runDrain(0, -1);

      $display("[TB] test 5: drain start with same-cycle psum");
      setCol(0, 0, 9);
      expRow[0][0] = 9;
      runDrain(0, -1);
      clearExp();

      $display("[TB] test 6: accumulator overflow");
      for (int i = 0; i < 256; i++) begin
         setCol(0, 0, 8388607);
         applyStimulus();
      end
      setCol(0, 0, 255);
      applyStimulus();
      setCol(0, 0, 1);
      applyStimulus();
`ifdef PSUM_SAT_EN
      expRow[0][0] = 32'h7FFF_FFFF;
`else
      expRow[0][0] = 32'h8000_0000;
`endif
      runDrain(0, -1);
      clearExp();

      $display("[TB] test 7: reset mid-drain");
      setCol(1, 2, 42);
      applyStimulus();
      bus.i_Drain_Start = 1'b1;
      applyStimulus();
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      checkOutput("mid-drain reset valid", DW'(bus.o_Out_Valid), DW'(0));
      checkOutput("mid-drain reset busy", DW'(bus.o_Busy), DW'(0));
      checkOutput("mid-drain reset done", DW'(bus.o_Done), DW'(0));
      checkOutput("mid-drain reset drop", DW'(bus.o_Drop), DW'(0));
      @(posedge CLK);
      #1;
      runDrain(0, -1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
